axi_rd_job_sched: RTL

- Read-job scheduler in front of the AXI read master's local command port (lcl_ostart/lcl_oaddr/lcl_onum/lcl_obusy/lcl_odone).
- Accepts one job (start address, total beat count) and splits it into AXI bursts. No burst crosses a 4 KB boundary, and no burst exceeds MAX_BURST beats.
- Caps outstanding bursts and counts burst completions.
- Signals job completion, or error/abort completion, to the action control logic.

---
 rtl/axi_rd_job_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axi_rd_job_sched.sv
// Read-job scheduler: splits one (address, beat count) job into AXI read
// bursts that never cross a 4 KB page and never exceed MAX_BURST beats,
// caps outstanding bursts and reports job completion / error.
module axi_rd_job_sched #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_BURST       = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_start,
  input  logic [ADDR_WIDTH-1:0] job_addr,
  input  logic [31:0]           job_beats,
  input  logic                  job_abort,
  output logic                  job_busy,
  output logic                  job_done,
  output logic                  job_err,
  output logic                  lcl_ostart,
  output logic [ADDR_WIDTH-1:0] lcl_oaddr,
  output logic [7:0]            lcl_onum,
  input  logic                  lcl_obusy,
  input  logic                  lcl_odone,
  input  logic [3:0]            rd_error,
  output logic [2:0]            out_cnt
);

  localparam int unsigned BPB     = DATA_WIDTH / 8;
  localparam int unsigned LOG_BPB = $clog2(BPB);
  localparam logic [31:0] MAX_B   = 32'(MAX_BURST);
  localparam logic [2:0]  MAX_OUT = 3'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [31:0]           rem_beats, rem_beats_nxt;
  logic                  err_flag, err_flag_nxt;

  logic                  job_busy_nxt, job_done_nxt, job_err_nxt;
  logic                  lcl_ostart_nxt;
  logic [ADDR_WIDTH-1:0] lcl_oaddr_nxt;
  logic [7:0]            lcl_onum_nxt;
  logic [2:0]            out_cnt_nxt;

  logic                  accept;
  logic                  odone_eff;
  logic                  err_now;
  logic [12:0]           to4k;
  logic [31:0]           len_calc;
  logic [31:0]           rem_after;
  logic [ADDR_WIDTH-1:0] addr_after;

  // Register all state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      rem_beats  <= '0;
      err_flag   <= 1'b0;
      job_busy   <= 1'b0;
      job_done   <= 1'b0;
      job_err    <= 1'b0;
      lcl_ostart <= 1'b0;
      lcl_oaddr  <= '0;
      lcl_onum   <= '0;
      out_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= cur_addr_nxt;
      rem_beats  <= rem_beats_nxt;
      err_flag   <= err_flag_nxt;
      job_busy   <= job_busy_nxt;
      job_done   <= job_done_nxt;
      job_err    <= job_err_nxt;
      lcl_ostart <= lcl_ostart_nxt;
      lcl_oaddr  <= lcl_oaddr_nxt;
      lcl_onum   <= lcl_onum_nxt;
      out_cnt    <= out_cnt_nxt;
    end
  end

  // Next-state, burst sizing and outstanding-count logic.
  always_comb begin
    accept    = lcl_ostart & ~lcl_obusy;
    odone_eff = lcl_odone & (out_cnt != '0);
    // Error / abort seen this cycle counts immediately, so no burst issues
    // after the cycle in which it appears.
    err_now   = err_flag | (job_busy & ((rd_error != '0) | job_abort));

    to4k      = (13'd4096 - {1'b0, cur_addr[11:0]}) >> LOG_BPB;
    len_calc  = rem_beats;
    if (MAX_B < len_calc)           len_calc = MAX_B;
    if ({19'b0, to4k} < len_calc)   len_calc = {19'b0, to4k};

    rem_after  = rem_beats - {24'b0, lcl_onum};
    addr_after = cur_addr + (ADDR_WIDTH'(lcl_onum) << LOG_BPB);

    state_nxt      = state;
    cur_addr_nxt   = cur_addr;
    rem_beats_nxt  = rem_beats;
    err_flag_nxt   = err_now;
    job_busy_nxt   = job_busy;
    job_done_nxt   = 1'b0;
    job_err_nxt    = 1'b0;
    lcl_ostart_nxt = lcl_ostart;
    lcl_oaddr_nxt  = lcl_oaddr;
    lcl_onum_nxt   = lcl_onum;
    out_cnt_nxt    = out_cnt + 3'(accept) - 3'(odone_eff);

    unique case (state)
      S_IDLE: begin
        if (job_start) begin
          cur_addr_nxt  = job_addr;
          rem_beats_nxt = job_beats;
          job_busy_nxt  = 1'b1;
          err_flag_nxt  = 1'b0;
          state_nxt     = S_CALC;
        end
      end
      S_CALC: begin
        lcl_oaddr_nxt = cur_addr;
        lcl_onum_nxt  = 8'(len_calc);
        if (rem_beats == '0) begin
          if (out_cnt_nxt == '0) begin
            job_done_nxt = 1'b1;
            job_err_nxt  = err_now;
            state_nxt    = S_DONE;
          end else begin
            state_nxt = S_WAIT;
          end
        end else if (err_now) begin
          state_nxt = S_WAIT;
        end else begin
          lcl_ostart_nxt = 1'b1;
          state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A posted request is never withdrawn, even if an error arrives.
        if (accept) begin
          lcl_ostart_nxt = 1'b0;
          cur_addr_nxt   = addr_after;
          rem_beats_nxt  = rem_after;
          if ((rem_after != '0) && (out_cnt_nxt < MAX_OUT) && !err_now)
            state_nxt = S_CALC;
          else
            state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if ((out_cnt_nxt == '0) && ((rem_beats == '0) || err_now)) begin
          job_done_nxt = 1'b1;
          job_err_nxt  = err_now;
          state_nxt    = S_DONE;
        end else if ((out_cnt_nxt < MAX_OUT) && (rem_beats != '0) && !err_now) begin
          state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        job_busy_nxt = 1'b0;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
